// File: rtl/hilo_div_if.sv
// hilo_div_if: divide request/result bundle between EX and the HI/LO divider
interface hilo_div_if;
  logic start;
  logic signed_div;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic cancel;
  logic stall_o;
  logic done_o;
  logic hilo_write_en;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  modport master(
    output start, signed_div, dividend, divisor, cancel,
    input stall_o, done_o, hilo_write_en, hi_o, lo_o
  );
  modport slave(
    input start, signed_div, dividend, divisor, cancel,
    output stall_o, done_o, hilo_write_en, hi_o, lo_o
  );
endinterface

// File: rtl/hilo_divider.sv
// hilo_divider: multi-cycle restoring DIV/DIVU unit producing a one-cycle HI/LO write
module hilo_divider (
  input logic clk,
  input logic rst,
  hilo_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [32:0] rem, shifted, diff, rem_n;
  logic [31:0] quo, quo_n, dvs, hi, lo, a_mag, b_mag;
  logic [4:0] count;
  logic sign_q, sign_r, accept, last;
  always_comb begin
    accept = state == IDLE && bus.start && !bus.cancel;
    a_mag = bus.signed_div && bus.dividend[31] ? -bus.dividend : bus.dividend;
    b_mag = bus.signed_div && bus.divisor[31] ? -bus.divisor : bus.divisor;
    shifted = {rem[31:0], quo[31]};
    diff = shifted - {1'b0, dvs};
    rem_n = diff[32] ? shifted : diff;
    quo_n = {quo[30:0], ~diff[32]};
    last = state == RUN && count == 5'd31;
    state_n = bus.cancel ? IDLE :
              state == IDLE ? (!bus.start ? IDLE : bus.divisor == '0 ? DONE : RUN) :
              state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      count <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else if (bus.cancel) begin
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      count <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (accept) begin
      sign_q <= bus.signed_div & bus.dividend[31];
      sign_r <= bus.signed_div & (bus.dividend[31] ^ bus.divisor[31]);
      dvs <= b_mag;
      rem <= '0;
      quo <= bus.divisor == '0 ? '0 : a_mag;
      count <= '0;
      if (bus.divisor == '0) begin
        hi <= '0;
        lo <= '0;
      end
    end else if (state == RUN) begin
      rem <= rem_n;
      quo <= quo_n;
      count <= count + 5'd1;
      // results are fixed up on the edge into DONE so hi/lo never follow live inputs
      if (last) begin
        hi <= sign_q ? -rem_n[31:0] : rem_n[31:0];
        lo <= sign_r ? -quo_n : quo_n;
      end
    end
  end
  assign bus.stall_o = accept || (state == RUN && !bus.cancel);
  assign bus.done_o = state == DONE && !bus.cancel;
  assign bus.hilo_write_en = state == DONE && !bus.cancel;
  assign bus.hi_o = hi;
  assign bus.lo_o = lo;
endmodule
